// File: rtl/ir_pkg.sv
// Shared constants for the EBOX IR/DRAM fetch sequencer.
package ir_pkg;

    localparam int unsigned FETCH_CNT_W     = 16;
    localparam int unsigned WAIT_CNT_W      = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned STATE_W         = 3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_MEM  = 3'd1;
    localparam logic [2:0] ST_LOAD_IR   = 3'd2;
    localparam logic [2:0] ST_LOAD_DRAM = 3'd3;
    localparam logic [2:0] ST_DISPATCH  = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

endpackage

// File: rtl/fetch_timer.sv
// Saturating memory-wait counter; expired flags the last wait cycle before timeout.
module fetch_timer
    import ir_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] count;
    logic [WAIT_CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (en && (count != CNT_MAX)) begin
            count_nxt = count + WAIT_CNT_W'(1);
        end
    end

    // expired is high while one more empty cycle would bring the count to TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_nxt;
            expired <= (count_nxt >= LAST_WAIT);
        end
    end

endmodule

// File: rtl/ir_fetch_seq.sv
// EBOX instruction-fetch sequencer: IR/DRAM latch strobes, dispatch handshake,
// halted-EBOX diagnostic loads and memory-wait timeout.
module ir_fetch_seq
    import ir_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   eboxClk,
    input  logic                   eboxResetN,
    input  logic                   fetchReq,
    input  logic                   cacheHit,
    input  logic                   mbXfer,
    input  logic                   abort,
    input  logic                   dispatchAck,
    input  logic                   eboxHalted,
    input  logic                   diagLoadIR,
    input  logic                   diagLoadDRAM,
    input  logic                   clearErr,
    output logic                   loadIR,
    output logic                   irSrcMB,
    output logic                   loadDRAM,
    output logic                   dispatchValid,
    output logic                   fetchBusy,
    output logic                   fetchTimeout,
    output logic                   diagReject,
    output logic [FETCH_CNT_W-1:0] fetchCount
);

    logic [STATE_W-1:0]     state;
    logic [STATE_W-1:0]     state_nxt;
    logic                   diag_pend;
    logic                   diag_pend_nxt;
    logic                   load_ir_nxt;
    logic                   src_mb_nxt;
    logic                   load_dram_nxt;
    logic                   timeout_nxt;
    logic                   reject_nxt;
    logic [FETCH_CNT_W-1:0] count_nxt;
    logic                   diag_req;
    logic                   diag_ok;
    logic                   tmr_clr;
    logic                   tmr_en;
    logic                   tmr_expired;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (eboxClk),
        .rst_n   (eboxResetN),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State register and registered outputs
    always_ff @(posedge eboxClk or negedge eboxResetN) begin
        if (!eboxResetN) begin
            state         <= ST_IDLE;
            diag_pend     <= 1'b0;
            loadIR        <= 1'b0;
            irSrcMB       <= 1'b0;
            loadDRAM      <= 1'b0;
            dispatchValid <= 1'b0;
            fetchBusy     <= 1'b0;
            fetchTimeout  <= 1'b0;
            diagReject    <= 1'b0;
            fetchCount    <= '0;
        end else begin
            state         <= state_nxt;
            diag_pend     <= diag_pend_nxt;
            loadIR        <= load_ir_nxt;
            irSrcMB       <= src_mb_nxt;
            loadDRAM      <= load_dram_nxt;
            dispatchValid <= (state_nxt == ST_DISPATCH);
            fetchBusy     <= (state_nxt != ST_IDLE);
            fetchTimeout  <= timeout_nxt;
            diagReject    <= reject_nxt;
            fetchCount    <= count_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nxt     = state;
        diag_pend_nxt = 1'b0;
        load_ir_nxt   = 1'b0;
        src_mb_nxt    = 1'b0;
        load_dram_nxt = 1'b0;
        timeout_nxt   = fetchTimeout;
        reject_nxt    = 1'b0;
        count_nxt     = fetchCount;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        diag_req = diagLoadIR | diagLoadDRAM;
        // A diagnostic IR+DRAM pair owns the cycle of its deferred DRAM strobe
        diag_ok  = (state == ST_IDLE) && eboxHalted && !fetchReq && !diag_pend;

        if (diag_pend) begin
            load_dram_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (fetchReq) begin
                    state_nxt = ST_WAIT_MEM;
                    tmr_clr   = 1'b1;
                end else if (diag_ok) begin
                    if (diagLoadIR) begin
                        load_ir_nxt   = 1'b1;
                        src_mb_nxt    = 1'b1;
                        diag_pend_nxt = diagLoadDRAM;
                    end else if (diagLoadDRAM) begin
                        load_dram_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cacheHit || mbXfer) begin
                    state_nxt   = ST_LOAD_IR;
                    load_ir_nxt = 1'b1;
                    src_mb_nxt  = mbXfer;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_nxt   = ST_ERROR;
                        timeout_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD_IR: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt     = ST_LOAD_DRAM;
                    load_dram_nxt = 1'b1;
                end
            end
            ST_LOAD_DRAM: begin
                state_nxt = abort ? ST_IDLE : ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (dispatchAck) begin
                    state_nxt = ST_IDLE;
                    count_nxt = fetchCount + FETCH_CNT_W'(1);
                end
            end
            ST_ERROR: begin
                if (clearErr) begin
                    state_nxt   = ST_IDLE;
                    timeout_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (diag_req && !diag_ok) begin
            reject_nxt = 1'b1;
        end
    end

endmodule

// File: doc/ir_fetch_seq.md
# ir_fetch_seq

Sequencer that owns the IR and DRAM latch strobes in the EBOX. It accepts an instruction-fetch request from the microcode and waits for instruction data from either the cache or the MB. It then strobes the IR latch, strobes the DRAM latch one cycle later, and presents a dispatch-ready handshake to the CRAM dispatch logic. It also arbitrates the halted-EBOX diagnostic IR/DRAM load path against normal fetches, and it times out stalled memory waits.

## Interface
- `TIMEOUT`, default 255: cycles allowed in the memory wait before a fetch timeout (1..255).
- `eboxClk`  in  1  EBOX clock; all state changes on its rising edge.
- `eboxResetN`  in  1  asynchronous, active-low reset.
- `fetchReq`  in  1  microcode requests an instruction fetch (level; sampled only in IDLE).
- `cacheHit`  in  1  instruction word valid on `cacheDataRead` this cycle.
- `mbXfer`  in  1  instruction word valid on `EDP_AD` through the MB this cycle.
- `abort`  in  1  page fail or interrupt; cancels any fetch in progress.
- `dispatchAck`  in  1  dispatch logic has consumed the decoded instruction.
- `eboxHalted`  in  1  EBOX halted; diagnostic loads are permitted.
- `diagLoadIR`  in  1  front-end request to strobe the IR latch.
- `diagLoadDRAM`  in  1  front-end request to strobe the DRAM latch.
- `clearErr`  in  1  clears `fetchTimeout`.
- `loadIR`  out  1  one-cycle IR latch strobe.
- `irSrcMB`  out  1  IR source select: 1 = MB/`EDP_AD`, 0 = cache; valid whenever `loadIR` = 1.
- `loadDRAM`  out  1  one-cycle DRAM latch strobe.
- `dispatchValid`  out  1  decoded instruction ready for dispatch.
- `fetchBusy`  out  1  sequencer is not in IDLE.
- `fetchTimeout`  out  1  sticky timeout error flag.
- `diagReject`  out  1  one-cycle pulse when a diagnostic request is refused.
- `fetchCount`  out  16  count of completed dispatches; wraps from 0xFFFF to 0.

## Operation
- States: IDLE, WAIT_MEM, LOAD_IR, LOAD_DRAM, DISPATCH, ERROR.
- IDLE: `fetchReq` = 1 moves to WAIT_MEM and clears the wait counter.
- WAIT_MEM, data arrival:
  - `cacheHit` or `mbXfer` = 1 moves to LOAD_IR.
  - `irSrcMB` is registered as `mbXfer`, so MB has priority when both are high.
- WAIT_MEM, no data: the wait counter increments each cycle. When the count reaches `TIMEOUT` with no data, the sequencer moves to ERROR and sets `fetchTimeout`.
- LOAD_IR: `loadIR` = 1 for exactly one cycle, then LOAD_DRAM.
- LOAD_DRAM: `loadDRAM` = 1 for exactly one cycle, then DISPATCH.
- DISPATCH:
  - `dispatchValid` = 1 and is held until `dispatchAck` is sampled high.
  - On acknowledge: return to IDLE and increment `fetchCount`.
- ERROR: remain until `clearErr` = 1, then return to IDLE. `fetchTimeout` clears in the same cycle.
- `abort` in WAIT_MEM, LOAD_IR, LOAD_DRAM or DISPATCH:
  - The next state is IDLE, and no further strobes are issued.
  - `abort` beats data arrival and `dispatchAck` in the same cycle.
  - `fetchCount` does not increment.
  - `abort` in IDLE or ERROR has no effect.
- Diagnostic path, accepted only in IDLE with `eboxHalted` = 1 and `fetchReq` = 0:
  - `diagLoadIR` produces `loadIR` the next cycle with `irSrcMB` = 1.
  - `diagLoadDRAM` produces `loadDRAM` the next cycle.
  - If both are requested, `loadIR` is issued first and `loadDRAM` the following cycle.
  - Neither produces `dispatchValid`.
  - Any diagnostic request outside these conditions produces a `diagReject` pulse the next cycle and is otherwise ignored.
  - `fetchReq` has priority over a diagnostic request in the same IDLE cycle; the diagnostic request is rejected.

## Timing
- All outputs are registered; no combinational paths from inputs to outputs.
- Reset values: state IDLE; `loadIR`, `irSrcMB`, `loadDRAM`, `dispatchValid`, `fetchBusy`, `fetchTimeout` and `diagReject` all 0; `fetchCount` = 0; wait counter 0.
- Latency, with `fetchReq` high at cycle 0 and data at cycle N (N ≥ 1):
  - `loadIR` = 1 at cycle N+1.
  - `loadDRAM` = 1 at cycle N+2.
  - `dispatchValid` = 1 from cycle N+3.
- Minimum fetch-to-dispatch latency is 4 cycles with data at cycle 1.
- `loadIR` and `loadDRAM` are never high in the same cycle.
- The wait counter is 8 bits and saturates; it never wraps.
- Reset asserted mid-fetch forces IDLE immediately; no strobe is emitted after reset deasserts until a new request arrives.

## Structure
- Package `ir_pkg`:
  - state enumeration;
  - `TIMEOUT` default;
  - `FETCH_CNT_W` = 16.
- Sub-module `fetch_timer`:
  - 8-bit wait counter with clear, enable and saturate;
  - `expired` output compares against `TIMEOUT`;
  - instantiated once.
- The state machine, diagnostic arbitration and `fetchCount` live in `ir_fetch_seq`.

## Test plan
- Cache fetch: `fetchReq` at cycle 0, `cacheHit` at cycle 2 -> `loadIR` at cycle 3 with `irSrcMB` = 0, `loadDRAM` at cycle 4, `dispatchValid` at cycle 5; `dispatchAck` at cycle 7 -> IDLE and `fetchCount` = 1.
- MB priority: `cacheHit` and `mbXfer` both high in WAIT_MEM -> `irSrcMB` = 1 during `loadIR`.
- Timeout, with `TIMEOUT` = 4 and no data -> ERROR with `fetchTimeout` = 1, and no `loadIR`; `clearErr` -> IDLE with the flag clear.
- Abort: `abort` in the same cycle as `cacheHit` -> no `loadIR`, IDLE next cycle, `fetchCount` unchanged; `abort` during DISPATCH -> `dispatchValid` drops.
- Diagnostics:
  - `eboxHalted` = 1 with `diagLoadIR` and `diagLoadDRAM` in IDLE -> `loadIR` next cycle, `loadDRAM` the cycle after, no `dispatchValid`.
  - The same request with `eboxHalted` = 0 -> a single `diagReject` pulse.
- Wrap and reset: `fetchCount` preset to 0xFFFF via 65535 fetches -> the next dispatch gives 0; `eboxResetN` low during LOAD_IR -> all outputs 0 immediately.
